cpu_seq_ctrl: RTL and testbench
===============================

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port run  input  1  level; start execution from IDLE.
REQ-005 SHALL have port inst_code  input  32  instruction word from the instruction ROM, valid in S_IF.
REQ-006 SHALL have port zf  input  1  ALU zero flag, valid in S_EX.
REQ-007 SHALL have port ir  output  32  instruction register.
REQ-008 SHALL have port pc_write  output  1  PC load strobe.
REQ-009 SHALL have port pc_src  output  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
REQ-010 SHALL have port rf_write, reg_dst, alu_src_b, ext_sel  output  1 each  regfile write, rd/rt select (1=rd), immediate operand select, zero-extend (1) / sign-extend (0).
REQ-011 SHALL have port alu_op  output  3  ALU operation code.
REQ-012 SHALL have port state  output  3  current state, for debug LEDs.
REQ-013 SHALL have port halted, illegal  output  1 each  halt status; one-cycle illegal-opcode pulse.
REQ-014 SHALL have port inst_cnt  output  CNT_W  retired-instruction count.

Function
REQ-015 SHALL implement a Moore FSM: S_IDLE=0, S_IF=1, S_ID=2, S_EX=3, S_WB=4, S_HALT=5; codes 6-7 SHALL go to S_IDLE.
REQ-016 S_IDLE: all strobes 0; run=1 -> S_IF next cycle, else stay.
REQ-017 S_IF: ir loads inst_code at the clock edge; pc_write=1, pc_src=00; -> S_ID.
REQ-018 S_ID: opcode=ir[31:26]; 000010 (j): pc_write=1, pc_src=10, inst_cnt+1, -> S_IF; 111111: -> S_HALT; 000000/000100/001000/001100/001101/001110 -> S_EX; any other opcode: illegal=1 for one cycle, inst_cnt unchanged, -> S_IF.
REQ-019 R-type funct->alu_op: 100100->000, 100101->001, 100110->010, 100111->011, 100000->100, 100010->101, 000100->110, 101011->111; any other funct: illegal=1 in S_EX, no writeback, -> S_IF.
REQ-020 I-type in S_EX/S_WB: alu_src_b=1, reg_dst=0; addi alu_op=100 ext_sel=0; andi 000, ori 001, xori 010, each ext_sel=1.
REQ-021 beq (000100) in S_EX: alu_op=101, alu_src_b=0; zf=1 -> pc_write=1, pc_src=01; either case inst_cnt+1, -> S_IF, no S_WB.
REQ-022 Valid R-type and I-type: S_EX -> S_WB; S_WB asserts rf_write=1 for exactly one cycle, inst_cnt+1, -> S_IF.
REQ-023 alu_op, reg_dst, alu_src_b, ext_sel SHALL be held stable across S_EX and S_WB for one instruction.
REQ-024 pc_write SHALL be asserted at most once per state visit; never in S_IDLE, S_WB, S_HALT.
REQ-025 S_HALT: halted=1, all strobes 0; exits only on rst; run ignored.
REQ-026 run is sampled only in S_IDLE; deasserting run mid-instruction SHALL NOT affect sequencing.
REQ-027 inst_cnt SHALL wrap from all-ones to 0 without flag.
REQ-028 Latency: R/I-type 4 cycles, beq 3, j 2, from S_IF entry to next S_IF entry.

Reset
REQ-029 rst=1 at a rising edge SHALL force state=S_IDLE, ir=0, inst_cnt=0, halted=0, illegal=0, all strobes 0, overriding any state including mid-instruction.
REQ-030 rst SHALL have priority over run and all other inputs in the same cycle.

Structure
REQ-031 State codes, opcode/funct constants and alu_op codes SHALL live in shared package cpu_ctrl_pkg, reused by ALU and datapath.
REQ-032 Funct-to-alu_op mapping SHALL be one combinational sub-module alu_func_dec (funct in, alu_op + valid out); the FSM stays in cpu_seq_ctrl.

Verification
REQ-033 rst=1 then run=1 with inst_code=32'h0022_1820 (add) -> states 1,2,3,4,1; rf_write=1 only in S_WB, alu_op=100, reg_dst=1, inst_cnt=1.
REQ-034 inst_code=32'h1000_0003 (beq), zf=1 -> pc_write=1, pc_src=01 in S_EX, no S_WB; zf=0 repeat -> pc_write=0 in S_EX.
REQ-035 inst_code=32'h0800_0010 (j) -> pc_src=10, pc_write=1 in S_ID, next state S_IF; inst_code=32'hFC00_0000 -> halted=1, stays with run toggling.
REQ-036 inst_code=32'h7C00_0000 (illegal opcode) and 32'h0000_003F (illegal funct) -> one-cycle illegal pulse, rf_write never 1, inst_cnt unchanged.
REQ-037 rst asserted in S_EX of addi 32'h2001_0005 -> next cycle state=0, ir=0, rf_write=0; CNT_W=4 run of 16 adds -> inst_cnt wraps to 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared constants for the multi-cycle CPU control path.
//
// Holds the sequencer state encoding, instruction opcode / funct constants,
// ALU operation codes and PC source selects. The ALU and datapath import
// this package so every block agrees on the same encodings.
package cpu_ctrl_pkg;

    // Sequencer states. Codes 6 and 7 are unused and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    // Primary opcodes (ir[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // R-type funct codes (ir[5:0]).
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // ALU operation codes.
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLLV = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    // PC source selects.
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Immediate-operand ALU instructions.
    function automatic logic is_itype_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI);
    endfunction

    // Opcodes that need an execute cycle.
    function automatic logic is_ex_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || is_itype_op(op);
    endfunction

endpackage

// File: rtl/alu_func_dec.sv
// alu_func_dec -- combinational R-type funct to ALU operation decoder.
//
// Ports:
//   funct  in   6  R-type function field, ir[5:0]
//   alu_op out  3  ALU operation code (ALU_AND when funct is unknown)
//   valid  out  1  funct is a supported R-type operation
module alu_func_dec
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; a missing default in always_comb infers a latch.
    always_comb begin
        alu_op = ALU_AND;
        valid  = 1'b1;
        case (funct)
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLLV: alu_op = ALU_SLLV;
            FN_SLTU: alu_op = ALU_SLTU;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl -- multi-cycle CPU sequencer (IF / ID / EX / WB) with halt.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset, highest priority
//   run        in   1      start request, only looked at in S_IDLE
//   inst_code  in   32     instruction word, captured into ir in S_IF
//   zf         in   1      ALU zero flag, used by beq in S_EX
//   ir         out  32     instruction register
//   pc_write   out  1      PC load strobe
//   pc_src     out  2      PC source: 00 PC+4, 01 branch, 10 jump
//   rf_write   out  1      register-file write strobe (S_WB only)
//   reg_dst    out  1      destination select, 1 = rd, 0 = rt
//   alu_src_b  out  1      ALU B operand, 1 = immediate
//   ext_sel    out  1      immediate extend, 1 = zero, 0 = sign
//   alu_op     out  3      ALU operation code
//   state      out  3      current state code, for debug
//   halted     out  1      sequencer parked in S_HALT
//   illegal    out  1      one-cycle pulse on unknown opcode or funct
//   inst_cnt   out  CNT_W  retired-instruction counter, wraps silently
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [31:0]      inst_code,
    input  logic             zf,
    output logic [31:0]      ir,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             rf_write,
    output logic             reg_dst,
    output logic             alu_src_b,
    output logic             ext_sel,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic [5:0] opcode;
    logic [2:0] fn_alu_op;
    logic       fn_valid;

    assign opcode = ir_q[31:26];

    alu_func_dec u_func_dec (
        .funct  (ir_q[5:0]),
        .alu_op (fn_alu_op),
        .valid  (fn_valid)
    );

    // Datapath selects depend only on ir, which is frozen from S_ID until
    // the next S_IF, so they stay stable across S_EX and S_WB.
    logic [2:0] dp_alu_op;
    logic       dp_reg_dst, dp_alu_src_b, dp_ext_sel;

    always_comb begin
        dp_alu_op    = ALU_AND;
        dp_reg_dst   = 1'b0;
        dp_alu_src_b = 1'b0;
        dp_ext_sel   = 1'b0;
        if (opcode == OP_RTYPE) begin
            dp_alu_op  = fn_alu_op;
            dp_reg_dst = 1'b1;
        end else if (opcode == OP_BEQ) begin
            dp_alu_op = ALU_SUB;
        end else if (is_itype_op(opcode)) begin
            dp_alu_src_b = 1'b1;
            case (opcode)
                OP_ADDI: dp_alu_op = ALU_ADD;
                OP_ANDI: begin dp_alu_op = ALU_AND; dp_ext_sel = 1'b1; end
                OP_ORI:  begin dp_alu_op = ALU_OR;  dp_ext_sel = 1'b1; end
                OP_XORI: begin dp_alu_op = ALU_XOR; dp_ext_sel = 1'b1; end
                default: dp_alu_op = ALU_AND;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF)
                ir_q <= inst_code;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        rf_write  = 1'b0;
        reg_dst   = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        alu_op    = ALU_AND;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_IF;
            end

            S_IF: begin
                pc_write = 1'b1;
                pc_src   = PC_SEQ;
                state_d  = S_ID;
            end

            S_ID: begin
                if (opcode == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_ex_op(opcode)) begin
                    state_d = S_EX;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end
            end

            S_EX: begin
                alu_op    = dp_alu_op;
                reg_dst   = dp_reg_dst;
                alu_src_b = dp_alu_src_b;
                ext_sel   = dp_ext_sel;
                if (opcode == OP_BEQ) begin
                    if (zf) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                    end
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if ((opcode == OP_RTYPE) && !fn_valid) begin
                    // Unknown funct: abandon the instruction without writeback.
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                alu_op    = dp_alu_op;
                reg_dst   = dp_reg_dst;
                alu_src_b = dp_alu_src_b;
                ext_sel   = dp_ext_sel;
                rf_write  = 1'b1;
                retire    = 1'b1;
                state_d   = S_IF;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ir       = ir_q;
    assign state    = state_q;
    assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl -- self-checking bench for cpu_seq_ctrl.
//
// A behavioural model classifies each instruction word into a kind and
// derives the expected state walk, control outputs and retire point from
// that kind. Two instances share stimulus: default width and CNT_W=4, the
// latter for counter wrap.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        zf  = 1'b0;
    logic [31:0] inst_code = '0;

    logic [31:0] ir;
    logic        pc_write, rf_write, reg_dst, alu_src_b, ext_sel, halted, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op, state;
    logic [15:0] inst_cnt;

    logic [31:0] d4_ir;
    logic        d4_pc_write, d4_rf_write, d4_reg_dst, d4_alu_src_b, d4_ext_sel;
    logic        d4_halted, d4_illegal;
    logic [1:0]  d4_pc_src;
    logic [2:0]  d4_alu_op, d4_state;
    logic [3:0]  d4_inst_cnt;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .inst_code(inst_code), .zf(zf),
        .ir(ir), .pc_write(pc_write), .pc_src(pc_src), .rf_write(rf_write),
        .reg_dst(reg_dst), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
        .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal),
        .inst_cnt(inst_cnt)
    );

    cpu_seq_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .inst_code(inst_code), .zf(zf),
        .ir(d4_ir), .pc_write(d4_pc_write), .pc_src(d4_pc_src),
        .rf_write(d4_rf_write), .reg_dst(d4_reg_dst), .alu_src_b(d4_alu_src_b),
        .ext_sel(d4_ext_sel), .alu_op(d4_alu_op), .state(d4_state),
        .halted(d4_halted), .illegal(d4_illegal), .inst_cnt(d4_inst_cnt)
    );

    // ---------------- reference model ----------------
    typedef enum {K_RTYPE, K_RBAD, K_ITYPE, K_BEQ, K_JUMP, K_BADOP, K_HALT} kind_e;
    typedef struct {
        kind_e      kind;
        logic [2:0] alu_op;
        logic       rd;
        logic       asb;
        logic       ext;
    } model_t;

    // Position in this table is the ALU code for that funct.
    localparam logic [5:0] FUNCT_TAB [8] = '{
        6'b100100, 6'b100101, 6'b100110, 6'b100111,
        6'b100000, 6'b100010, 6'b000100, 6'b101011
    };

    function automatic model_t classify(input logic [31:0] w);
        model_t     m;
        logic [5:0] op;
        op = w[31:26];
        m  = '{K_BADOP, 3'b000, 1'b0, 1'b0, 1'b0};
        if (op == 6'd0) begin
            m.kind = K_RBAD;
            for (int i = 0; i < 8; i++)
                if (w[5:0] == FUNCT_TAB[i]) begin
                    m.kind = K_RTYPE; m.alu_op = 3'(i); m.rd = 1'b1;
                end
        end
        else if (op == 6'd4)  begin m.kind = K_BEQ; m.alu_op = 3'd5; end
        else if (op == 6'd2)  m.kind = K_JUMP;
        else if (op == 6'd63) m.kind = K_HALT;
        else if (op == 6'd8)  begin m.kind = K_ITYPE; m.asb = 1; m.alu_op = 3'd4; end
        else if (op == 6'd12) begin m.kind = K_ITYPE; m.asb = 1; m.alu_op = 3'd0; m.ext = 1; end
        else if (op == 6'd13) begin m.kind = K_ITYPE; m.asb = 1; m.alu_op = 3'd1; m.ext = 1; end
        else if (op == 6'd14) begin m.kind = K_ITYPE; m.asb = 1; m.alu_op = 3'd2; m.ext = 1; end
        return m;
    endfunction

    // Output vector: {pc_write, pc_src[1:0], rf_write, reg_dst, alu_src_b,
    //                 ext_sel, alu_op[2:0], halted, illegal}
    function automatic logic [11:0] obs_vec();
        return {pc_write, pc_src, rf_write, reg_dst, alu_src_b, ext_sel,
                alu_op, halted, illegal};
    endfunction

    // ---------------- scenario tasks ----------------

    // Runs one instruction from its S_IF cycle. Precondition: the next
    // falling edge lands in S_IF.
    task automatic exec_inst(input logic [31:0] code, input logic zf_v, input string tag);
        model_t      m;
        int          n, ret;
        logic [11:0] exp, mask, obs;
        m = classify(code);
        case (m.kind)
            K_RTYPE, K_ITYPE: begin n = 4; ret = 3;  end
            K_RBAD:           begin n = 3; ret = -1; end
            K_BEQ:            begin n = 3; ret = 2;  end
            K_JUMP:           begin n = 2; ret = 1;  end
            default:          begin n = 2; ret = -1; end
        endcase
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            run       = 1'($urandom);
            inst_code = (p == 0) ? code : $urandom();
            zf        = (p == 2) ? zf_v : 1'($urandom);
            #1;
            exp  = '0;
            mask = '1;
            if (p < 2) mask[7:2] = '0;
            if (p == 0) exp[11] = 1'b1;
            if (p == 1 && m.kind == K_JUMP)  begin exp[11] = 1'b1; exp[10:9] = 2'b10; end
            if (p == 1 && m.kind == K_BADOP) exp[0] = 1'b1;
            if (p >= 2) begin
                if (m.kind == K_RBAD) begin
                    exp[0]    = 1'b1;
                    mask[7:2] = '0;
                end else begin
                    exp[7] = m.rd; exp[6] = m.asb; exp[5] = m.ext; exp[4:2] = m.alu_op;
                end
                if (m.kind == K_BEQ && zf_v) begin exp[11] = 1'b1; exp[10:9] = 2'b01; end
                if (p == 3) exp[8] = 1'b1;
            end
            if (!exp[11]) mask[10:9] = '0;
            obs = obs_vec();
            total++;
            if ((obs & mask) !== (exp & mask)) begin
                bad++;
                $display("FAIL %s ctrl phase=%0d got=%h want=%h mask=%h", tag, p, obs, exp, mask);
            end
            total++;
            if (state !== 3'(p + 1) || d4_state !== 3'(p + 1)) begin
                bad++;
                $display("FAIL %s state phase=%0d got=%0d/%0d want=%0d", tag, p, state, d4_state, p + 1);
            end
            if (p > 0) begin
                total++;
                if (ir !== code) begin
                    bad++;
                    $display("FAIL %s ir phase=%0d got=%h want=%h", tag, p, ir, code);
                end
            end
            total++;
            if (inst_cnt !== 16'(model_cnt) || d4_inst_cnt !== 4'(model_cnt)) begin
                bad++;
                $display("FAIL %s inst_cnt phase=%0d got=%0d/%0d want=%0d", tag, p,
                         inst_cnt, d4_inst_cnt, model_cnt);
            end
            if (p == ret) model_cnt++;
        end
    endtask

    // Asserts rst together with run=1; leaves rst high at a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; run = 1'b1; inst_code = $urandom();
        @(negedge clk);
        #1;
        model_cnt = 0;
        total++;
        if (state !== 3'd0 || ir !== 32'd0 || inst_cnt !== 16'd0 || obs_vec() !== 12'd0 ||
            d4_state !== 3'd0 || d4_inst_cnt !== 4'd0) begin
            bad++;
            $display("FAIL %s reset got state=%0d ir=%h cnt=%0d ctrl=%h want 0", tag,
                     state, ir, inst_cnt, obs_vec());
        end
    endtask

    // Called at a falling edge in S_IDLE; next falling edge is S_IF.
    task automatic start_run();
        rst = 1'b0; run = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset");
        rst = 1'b0; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (state !== 3'd0 || obs_vec() !== 12'd0) begin
                bad++;
                $display("FAIL idle_hold got state=%0d ctrl=%h want 0/000", state, obs_vec());
            end
        end
        start_run();
    endtask

    task automatic test_add();
        exec_inst(32'h0022_1820, 1'b0, "add");
    endtask

    task automatic test_beq();
        exec_inst(32'h1000_0003, 1'b1, "beq_taken");
        exec_inst(32'h1000_0003, 1'b0, "beq_not_taken");
    endtask

    task automatic test_jump();
        exec_inst(32'h0800_0010, 1'b0, "jump");
        exec_inst(32'h0800_0010, 1'b1, "jump2");
    endtask

    task automatic test_illegal();
        exec_inst(32'h7C00_0000, 1'b0, "bad_opcode");
        exec_inst(32'h0000_003F, 1'b0, "bad_funct");
        exec_inst(32'h3002_00FF, 1'b0, "andi_after_bad");
    endtask

    task automatic test_random(input int count);
        logic [31:0] w;
        logic [5:0]  iops [4];
        iops = '{6'd8, 6'd12, 6'd13, 6'd14};
        for (int k = 0; k < count; k++) begin
            w = $urandom();
            case ($urandom_range(0, 9))
                0, 1, 2: begin w[31:26] = 6'd0; w[5:0] = FUNCT_TAB[$urandom_range(0, 7)]; end
                3:       w[31:26] = 6'd0;
                4, 5:    w[31:26] = iops[$urandom_range(0, 3)];
                6:       w[31:26] = 6'd4;
                7:       w[31:26] = 6'd2;
                8:       if (w[31:26] == 6'd63) w[31:26] = 6'd62;
                default: w[31:26] = 6'd8;
            endcase
            exec_inst(w, 1'($urandom), "random");
        end
    endtask

    // Reset in the middle of an addi: sequencer must drop to S_IDLE at once.
    task automatic test_reset_mid();
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            run = 1'b1;
            inst_code = (p == 0) ? 32'h2001_0005 : $urandom();
        end
        #1;
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL reset_mid pre got state=%0d want=3", state);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        model_cnt = 0;
        total++;
        if (state !== 3'd0 || ir !== 32'd0 || rf_write !== 1'b0 ||
            inst_cnt !== 16'd0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got state=%0d ir=%h rf_write=%b cnt=%0d want 0",
                     state, ir, rf_write, inst_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset("wrap_reset");
        start_run();
        for (int k = 0; k < 16; k++)
            exec_inst({6'd0, 15'($urandom), 5'd0, 6'b100000}, 1'($urandom), "wrap_add");
        @(negedge clk);
        #1;
        total++;
        if (d4_inst_cnt !== 4'd0 || inst_cnt !== 16'd16) begin
            bad++;
            $display("FAIL wrap got cnt4=%0d cnt16=%0d want 0/16", d4_inst_cnt, inst_cnt);
        end
        do_reset("wrap_end");
        start_run();
    endtask

    task automatic test_halt();
        exec_inst(32'h0800_0010, 1'b0, "pre_halt_j");
        exec_inst(32'hFC00_0000, 1'b0, "halt");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run = 1'($urandom); zf = 1'($urandom); inst_code = $urandom();
            #1;
            total++;
            if (state !== 3'd5 || obs_vec() !== 12'b0000_0000_0010 ||
                inst_cnt !== 16'(model_cnt)) begin
                bad++;
                $display("FAIL halt_hold cycle=%0d got state=%0d ctrl=%h cnt=%0d want 5/002/%0d",
                         i, state, obs_vec(), inst_cnt, model_cnt);
            end
        end
        do_reset("halt_exit");
    endtask

    initial begin
        test_reset();
        test_add();
        test_beq();
        test_jump();
        test_illegal();
        test_random(60);
        test_reset_mid();
        test_wrap();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
